// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and data stage,
//            with data priority, fetch anti-starvation and access timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [3:0]    dm_bmask,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_bmask,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] c_skip_max  = SW'(STARVE_MAX);
    localparam logic [TW-1:0] c_tout_last = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_DM = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_skip, w_skip_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic          r_cancel, w_cancel_nxt;

    logic          w_mem_req_nxt, w_mem_we_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_mem_wdata_nxt;
    logic [3:0]    w_mem_bmask_nxt;
    logic          w_if_done_nxt, w_dm_done_nxt, w_dm_err_nxt;
    logic [DW-1:0] w_if_rdata_nxt, w_dm_rdata_nxt;
    logic          w_flushed;
    logic          w_tout;

    assign stall     = (if_req & ~if_done) | (dm_req & ~dm_done);
    assign w_flushed = r_cancel | if_flush;
    assign w_tout    = (r_tcnt == c_tout_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_skip    <= '0;
            r_tcnt    <= '0;
            r_cancel  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_bmask <= '0;
            if_done   <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_skip    <= w_skip_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_cancel  <= w_cancel_nxt;
            mem_req   <= w_mem_req_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            mem_bmask <= w_mem_bmask_nxt;
            if_done   <= w_if_done_nxt;
            if_rdata  <= w_if_rdata_nxt;
            dm_done   <= w_dm_done_nxt;
            dm_rdata  <= w_dm_rdata_nxt;
            dm_err    <= w_dm_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_skip_nxt      = r_skip;
        w_tcnt_nxt      = r_tcnt;
        w_cancel_nxt    = r_cancel;
        w_mem_req_nxt   = mem_req;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_mem_bmask_nxt = mem_bmask;
        w_if_done_nxt   = 1'b0;
        w_dm_done_nxt   = 1'b0;
        w_dm_err_nxt    = 1'b0;
        w_if_rdata_nxt  = if_rdata;
        w_dm_rdata_nxt  = dm_rdata;

        case (r_state)
            S_IDLE: begin
                w_cancel_nxt = 1'b0;
                w_tcnt_nxt   = '0;
                // Data wins ties unless fetch has already been skipped STARVE_MAX times.
                if (if_req && (!dm_req || r_skip == c_skip_max)) begin
                    w_state_nxt     = S_BUSY_IF;
                    w_skip_nxt      = '0;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = '0;
                    w_mem_bmask_nxt = 4'hF;
                end else if (dm_req) begin
                    w_state_nxt     = S_BUSY_DM;
                    if (if_req && r_skip != c_skip_max)
                        w_skip_nxt = r_skip + SW'(1);
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    w_mem_bmask_nxt = dm_bmask;
                end
            end
            S_BUSY_IF: begin
                if (mem_ack) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_cancel_nxt  = 1'b0;
                    if (!w_flushed) begin
                        w_if_done_nxt  = 1'b1;
                        w_if_rdata_nxt = mem_rdata;
                    end
                end else if (w_tout) begin
                    // Fetch timeout is silent: requester still holds if_req and is re-granted.
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_cancel_nxt  = 1'b0;
                end else begin
                    w_tcnt_nxt   = r_tcnt + TW'(1);
                    w_cancel_nxt = w_flushed;
                end
            end
            S_BUSY_DM: begin
                if (mem_ack) begin
                    w_state_nxt    = S_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_dm_done_nxt  = 1'b1;
                    w_dm_rdata_nxt = mem_rdata;
                end else if (w_tout) begin
                    w_state_nxt    = S_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_dm_done_nxt  = 1'b1;
                    w_dm_err_nxt   = 1'b1;
                    w_dm_rdata_nxt = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (directed + random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int STARVE_MAX = 3;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_flush, if_done;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_done, dm_err;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic [3:0]    dm_bmask;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_bmask;
    logic          stall;

    int n_checks = 0;
    int n_fail   = 0;
    int skip_m   = 0;
    logic [DW-1:0] exp_if_rdata, exp_dm_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_bmask(dm_bmask), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_bmask(mem_bmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [136:0] all_outs();
        return {mem_req, mem_we, mem_addr, mem_wdata, mem_bmask,
                if_done, dm_done, if_rdata, dm_rdata, dm_err};
    endfunction

    function automatic logic [69:0] mem_pl();
        return {mem_req, mem_we, mem_addr, mem_wdata, mem_bmask};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_bmask = '0;
        mem_ack = 0; mem_rdata = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL reset_async outs=%h expected 0", all_outs());
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({all_outs(), stall} !== '0) begin
            n_fail++; $display("FAIL reset_release outs=%h stall=%b expected 0", all_outs(), stall);
        end
    endtask

    task automatic test_fetch_basic();
        if_req = 1; if_addr = 32'h0000_0010;
        tick();
        n_checks++;
        if (mem_pl() !== {1'b1, 1'b0, 32'h10, 32'h0, 4'hF}) begin
            n_fail++; $display("FAIL fetch_mem_pl got=%h exp=%h", mem_pl(), {1'b1, 1'b0, 32'h10, 32'h0, 4'hF});
        end
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        tick();
        n_checks++;
        if ({if_done, if_rdata, mem_req} !== {1'b1, 32'h13, 1'b0}) begin
            n_fail++; $display("FAIL fetch_done done=%b rdata=%h mem_req=%b exp 1/13/0", if_done, if_rdata, mem_req);
        end
        if_req = 0; mem_ack = 0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        n_checks++;
        if ({if_done, if_rdata} !== {1'b0, 32'h13}) begin
            n_fail++; $display("FAIL fetch_pulse done=%b rdata=%h exp 0/13", if_done, if_rdata);
        end
        skip_m = 0;
    endtask

    task automatic test_priority();
        int got = 0;
        int cyc = 0;
        logic exp_is_if, got_is_if;
        if_addr = 32'h100; dm_addr = 32'h200; dm_we = 0; dm_wdata = '0; dm_bmask = 4'hF;
        if_req = 1; dm_req = 1;
        while (got < 8 && cyc < 80) begin
            tick(); cyc++;
            mem_ack = 0;
            if (mem_req) begin
                exp_is_if = (skip_m == STARVE_MAX);
                skip_m = exp_is_if ? 0 : ((skip_m < STARVE_MAX) ? skip_m + 1 : skip_m);
                got_is_if = (mem_addr == 32'h100);
                n_checks++;
                if (got_is_if !== exp_is_if) begin
                    n_fail++; $display("FAIL priority_grant%0d got_if=%b exp_if=%b", got, got_is_if, exp_is_if);
                end
                got++;
                mem_ack = 1; mem_rdata = $urandom;
                if (got == 8) begin if_req = 0; dm_req = 0; end
            end
        end
        n_checks++;
        if (got != 8) begin
            n_fail++; $display("FAIL priority_count got=%0d exp=8", got);
        end
        if_req = 0; dm_req = 0;
        tick(); mem_ack = 0;
        tick();
    endtask

    task automatic test_store_wait();
        logic [69:0] exp_pl;
        dm_req = 1; dm_we = 1; dm_addr = 32'h1000_0000; dm_wdata = 32'hA5; dm_bmask = 4'b0001;
        exp_pl = {1'b1, 1'b1, 32'h1000_0000, 32'hA5, 4'b0001};
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({mem_pl(), dm_done} !== {exp_pl, 1'b0}) begin
                n_fail++; $display("FAIL store_hold%0d pl=%h done=%b exp=%h/0", i, mem_pl(), dm_done, exp_pl);
            end
            if (i == 3) begin mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; end
            tick();
        end
        n_checks++;
        if ({dm_done, dm_err, dm_rdata, mem_req} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++; $display("FAIL store_done done=%b err=%b rdata=%h mem_req=%b", dm_done, dm_err, dm_rdata, mem_req);
        end
        dm_req = 0; mem_ack = 0;
        tick();
        n_checks++;
        if (dm_done !== 1'b0) begin
            n_fail++; $display("FAIL store_pulse done=%b exp 0", dm_done);
        end
    endtask

    task automatic test_timeout();
        int cnt = 0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000_0040; dm_wdata = '0; dm_bmask = 4'hF;
        tick();
        while (mem_req && cnt < 40) begin
            if (dm_done || dm_err) begin
                n_checks++; n_fail++;
                $display("FAIL timeout_early done=%b err=%b at busy cycle %0d", dm_done, dm_err, cnt);
            end
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != TIMEOUT) begin
            n_fail++; $display("FAIL timeout_len busy=%0d exp=%0d", cnt, TIMEOUT);
        end
        n_checks++;
        if ({dm_done, dm_err, dm_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL timeout_done done=%b err=%b rdata=%h exp 1/1/0", dm_done, dm_err, dm_rdata);
        end
        dm_req = 0;
        tick();
        n_checks++;
        if ({dm_done, dm_err} !== 2'b00) begin
            n_fail++; $display("FAIL timeout_err_pulse done=%b err=%b exp 0/0", dm_done, dm_err);
        end
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 32'h300;
        tick();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
            n_fail++; $display("FAIL flush_grant mem_req=%b addr=%h exp 1/300", mem_req, mem_addr);
        end
        dm_req = 1; dm_we = 0; dm_addr = 32'h400; dm_bmask = 4'hF;
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; if_req = 0; mem_ack = 1; mem_rdata = 32'h77;
        tick();
        mem_ack = 0;
        n_checks++;
        if ({if_done, mem_req} !== 2'b00) begin
            n_fail++; $display("FAIL flush_suppress if_done=%b mem_req=%b exp 0/0", if_done, mem_req);
        end
        tick();
        n_checks++;
        if ({mem_req, mem_addr, if_done} !== {1'b1, 32'h400, 1'b0}) begin
            n_fail++; $display("FAIL flush_dm_grant mem_req=%b addr=%h if_done=%b", mem_req, mem_addr, if_done);
        end
        mem_ack = 1; mem_rdata = 32'h55;
        tick();
        n_checks++;
        if ({dm_done, dm_rdata, if_done} !== {1'b1, 32'h55, 1'b0}) begin
            n_fail++; $display("FAIL flush_dm_done done=%b rdata=%h if_done=%b", dm_done, dm_rdata, if_done);
        end
        dm_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'h1234; dm_bmask = 4'h3;
        tick();
        tick();
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_busy mem_req=%b exp 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++; $display("FAIL rstmid_async outs=%h expected 0", all_outs());
        end
        dm_req = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ack = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({dm_done, mem_req, if_done} !== 3'b000) begin
                n_fail++; $display("FAIL rstmid_quiet%0d dm_done=%b mem_req=%b if_done=%b", i, dm_done, mem_req, if_done);
            end
        end
        mem_ack = 0;
        skip_m = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int pat, n_own, w;
            logic first_if, is_if;
            logic [AW-1:0] ia, da;
            logic [DW-1:0] dwd, rd;
            logic dwe;
            logic [3:0] dbm;
            logic [69:0] exp_pl;
            pat = $urandom_range(0, 2);
            ia = $urandom; da = $urandom; dwd = $urandom;
            dwe = 1'($urandom_range(0, 1)); dbm = 4'($urandom_range(0, 15));
            if_addr = ia; dm_addr = da; dm_we = dwe; dm_wdata = dwd; dm_bmask = dbm;
            if_req = (pat != 1); dm_req = (pat != 0);
            n_own = (pat == 2) ? 2 : 1;
            first_if = (pat == 0) || (pat == 2 && skip_m == STARVE_MAX);
            for (int k = 0; k < n_own; k++) begin
                is_if = (k == 0) ? first_if : !first_if;
                if (is_if) skip_m = 0;
                else if (if_req) skip_m = (skip_m < STARVE_MAX) ? skip_m + 1 : skip_m;
                exp_pl = is_if ? {1'b1, 1'b0, ia, 32'h0, 4'hF} : {1'b1, dwe, da, dwd, dbm};
                w = $urandom_range(0, 4);
                rd = $urandom;
                tick();
                for (int i = 0; i <= w; i++) begin
                    n_checks++;
                    if ({mem_pl(), stall} !== {exp_pl, 1'b1}) begin
                        n_fail++; $display("FAIL rand%0d_busy%0d pl=%h stall=%b exp=%h/1", it, i, mem_pl(), stall, exp_pl);
                    end
                    if (i == w) begin mem_ack = 1; mem_rdata = rd; end
                    else begin mem_rdata = $urandom; tick(); end
                end
                tick();
                mem_ack = 0;
                if (is_if) exp_if_rdata = rd; else exp_dm_rdata = rd;
                n_checks++;
                if ({if_done, dm_done, dm_err, if_rdata, dm_rdata} !==
                    {is_if, !is_if, 1'b0, exp_if_rdata, exp_dm_rdata}) begin
                    n_fail++;
                    $display("FAIL rand%0d_done if_done=%b dm_done=%b err=%b if_rd=%h dm_rd=%h exp %b/%b/0/%h/%h",
                             it, if_done, dm_done, dm_err, if_rdata, dm_rdata, is_if, !is_if, exp_if_rdata, exp_dm_rdata);
                end
                if (is_if) if_req = 0; else dm_req = 0;
            end
            tick();
            n_checks++;
            if ({mem_req, if_done, dm_done, stall} !== 4'b0000) begin
                n_fail++; $display("FAIL rand%0d_idle mem_req=%b if_done=%b dm_done=%b stall=%b", it, mem_req, if_done, dm_done, stall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_basic();
        test_priority();
        test_store_wait();
        test_timeout();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
